// File: rtl/read_address_sequencer_if.sv
// rtl/read_address_sequencer_if.sv - register-file read port and output beat stream of read_address_sequencer
// OutLast exists only when READ_LAST_EN is defined.
interface read_address_sequencer_if #(
    parameter int ADDRESS   = 4,
    parameter int DATAWIDTH = 8
);
    logic                 Start;
    logic [ADDRESS-1:0]   ReadReg;
    logic [DATAWIDTH-1:0] RdData;
    logic [DATAWIDTH-1:0] DataOut;
    logic                 OutValid;
    logic                 OutReady;
    logic                 Busy;
    logic                 Done;
`ifdef READ_LAST_EN
    logic                 OutLast;

    modport master (
        input  Start, RdData, OutReady,
        output ReadReg, DataOut, OutValid, Busy, Done, OutLast
    );
    modport slave (
        output Start, RdData, OutReady,
        input  ReadReg, DataOut, OutValid, Busy, Done, OutLast
    );
`else
    modport master (
        input  Start, RdData, OutReady,
        output ReadReg, DataOut, OutValid, Busy, Done
    );
    modport slave (
        output Start, RdData, OutReady,
        input  ReadReg, DataOut, OutValid, Busy, Done
    );
`endif
endinterface

// File: rtl/read_address_sequencer.sv
// rtl/read_address_sequencer.sv - reads DATANUM register-file entries in order and streams them over valid/ready
// Optional READ_LAST_EN adds OutLast, marking the final beat of a burst.
module read_address_sequencer #(
    parameter int ADDRESS   = 4,
    parameter int DATAWIDTH = 8,
    parameter int DATANUM   = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    read_address_sequencer_if.master bus
);
    localparam int                 CW        = $clog2(DATANUM + 1);
    localparam logic [CW-1:0]      NUM       = CW'(DATANUM);
    localparam logic [ADDRESS-1:0] LAST_ADDR = ADDRESS'(DATANUM - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDRESS-1:0]   addr_q, addr_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic [CW-1:0]        issued_q, issued_d;
    logic [CW-1:0]        accepted_q, accepted_d;
    logic                 load;
    logic                 accept;
`ifdef READ_LAST_EN
    logic                 last_q, last_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            issued_q   <= '0;
            accepted_q <= '0;
`ifdef READ_LAST_EN
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
`ifdef READ_LAST_EN
            last_q     <= last_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        load       = 1'b0;
        accept     = 1'b0;
`ifdef READ_LAST_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                addr_d     = '0;
                issued_d   = '0;
                accepted_d = '0;
                if (bus.Start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // The output register refills whenever it is empty or being drained this edge.
                load   = (!valid_q || bus.OutReady) && (issued_q < NUM);
                accept = valid_q && bus.OutReady;
                if (load) begin
                    data_d   = bus.RdData;
                    valid_d  = 1'b1;
                    issued_d = issued_q + 1'b1;
                    addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
`ifdef READ_LAST_EN
                    last_d   = (issued_q == NUM - 1'b1);
`endif
                end else if (accept) begin
                    valid_d = 1'b0;
`ifdef READ_LAST_EN
                    last_d  = 1'b0;
`endif
                end
                if (accept) begin
                    accepted_d = accepted_q + 1'b1;
                    if (accepted_q == NUM - 1'b1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ReadReg  = addr_q;
    assign bus.DataOut  = data_q;
    assign bus.OutValid = valid_q;
    assign bus.Busy     = (state_q == STREAM);
    assign bus.Done     = (state_q == DONE);
`ifdef READ_LAST_EN
    assign bus.OutLast  = last_q;
`endif

endmodule

// File: tb/tb_read_address_sequencer.sv
// tb/tb_read_address_sequencer.sv - randomized self-checking bench for read_address_sequencer
// Covers OutLast as well when READ_LAST_EN is defined.
module tb_read_address_sequencer;
    localparam int ADDRESS   = 4;
    localparam int DATAWIDTH = 8;
    localparam int DATANUM   = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    read_address_sequencer_if #(.ADDRESS(ADDRESS), .DATAWIDTH(DATAWIDTH)) bus ();

    read_address_sequencer #(
        .ADDRESS(ADDRESS), .DATAWIDTH(DATAWIDTH), .DATANUM(DATANUM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DATAWIDTH-1:0] rf [0:(1<<ADDRESS)-1];
    assign bus.RdData = rf[bus.ReadReg];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATAWIDTH-1:0] got_q[$];
    bit                   last_q[$];
    logic [DATAWIDTH-1:0] held_d_q[$];
    logic [ADDRESS-1:0]   held_r_q[$];
    bit                   held_l_q[$];
    int first_valid_c, done_c, done_cnt, last_acc_c;
    bit timeout, aborted;
    logic [ADDRESS-1:0]   rst_rr;
    logic [DATAWIDTH-1:0] rst_do;
    logic                 rst_ov, rst_busy, rst_done;

    task automatic fill_rf(input bit rnd);
        for (int k = 0; k < (1 << ADDRESS); k++)
            rf[k] = rnd ? DATAWIDTH'($urandom) : DATAWIDTH'(8'h10 + k);
    endtask

    // Pulses Start, then steers OutReady cycle by cycle and records what the stream delivers.
    task automatic run_burst(input int stall_beat, input int stall_len, input int start_at_beat,
                             input int rst_at_beat, input bit rnd_ready);
        int  c = 0;
        int  stall_left = 0;
        bit  stalled = 0;
        bit  restarted = 0;
        got_q.delete(); last_q.delete(); held_d_q.delete(); held_r_q.delete(); held_l_q.delete();
        first_valid_c = -1; done_c = -1; done_cnt = 0; last_acc_c = -1; timeout = 0; aborted = 0;
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.OutReady = 1'b1;
        forever begin
            @(negedge clk);
            c++;
            bus.Start = 1'b0;
            if (bus.Done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (bus.OutValid && first_valid_c < 0) first_valid_c = c;
            if (rst_at_beat >= 0 && bus.OutValid && got_q.size() == rst_at_beat) begin
                rst_n = 1'b0;
                #1;
                rst_rr = bus.ReadReg; rst_do = bus.DataOut; rst_ov = bus.OutValid;
                rst_busy = bus.Busy; rst_done = bus.Done;
                aborted = 1;
                break;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
            if (c > 400) begin
                timeout = 1;
                break;
            end
            if (!stalled && stall_len > 0 && bus.OutValid && got_q.size() == stall_beat) begin
                stalled    = 1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                stall_left--;
                bus.OutReady = 1'b0;
                held_d_q.push_back(bus.DataOut);
                held_r_q.push_back(bus.ReadReg);
`ifdef READ_LAST_EN
                held_l_q.push_back(bus.OutLast);
`endif
            end else begin
                bus.OutReady = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!restarted && start_at_beat >= 0 && bus.OutValid && got_q.size() == start_at_beat) begin
                restarted = 1;
                bus.Start = 1'b1;
            end
            if (bus.OutValid && bus.OutReady) begin
                got_q.push_back(bus.DataOut);
                last_acc_c = c;
`ifdef READ_LAST_EN
                last_q.push_back(bus.OutLast);
`else
                last_q.push_back(1'b0);
`endif
            end
        end
        bus.OutReady = 1'b1;
    endtask

    task automatic test_reset();
        bus.Start = 1'b0; bus.OutReady = 1'b0; rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.ReadReg, bus.DataOut, bus.OutValid, bus.Busy, bus.Done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ReadReg=%0h DataOut=%0h OutValid=%0b Busy=%0b Done=%0b, required all 0",
                     bus.ReadReg, bus.DataOut, bus.OutValid, bus.Busy, bus.Done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.ReadReg, bus.OutValid, bus.Busy, bus.Done} !== '0) begin
                n_fail++;
                $display("FAIL idle_cycle_%0d: ReadReg=%0h OutValid=%0b Busy=%0b Done=%0b, required all 0",
                         i, bus.ReadReg, bus.OutValid, bus.Busy, bus.Done);
            end
        end
    endtask

    task automatic test_full_rate();
        fill_rf(0);
        run_burst(-1, 0, -1, -1, 0);
        n_checks++;
        if (timeout !== 0) begin n_fail++; $display("FAIL full_timeout: burst never completed, required Done within 400 cycles"); end
        n_checks++;
        if (first_valid_c !== 2) begin n_fail++; $display("FAIL full_first_valid: cycle %0d, required 2", first_valid_c); end
        n_checks++;
        if (got_q.size() !== DATANUM) begin n_fail++; $display("FAIL full_beat_count: %0d, required %0d", got_q.size(), DATANUM); end
        for (int k = 0; k < got_q.size() && k < DATANUM; k++) begin
            n_checks++;
            if (got_q[k] !== rf[k]) begin n_fail++; $display("FAIL full_beat_%0d: %0h, required %0h", k, got_q[k], rf[k]); end
        end
        n_checks++;
        if (last_acc_c !== first_valid_c + DATANUM - 1) begin
            n_fail++; $display("FAIL full_consecutive: last beat cycle %0d, required %0d", last_acc_c, first_valid_c + DATANUM - 1);
        end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_count: %0d, required 1", done_cnt); end
        n_checks++;
        if (done_c !== last_acc_c + 1) begin n_fail++; $display("FAIL full_done_cycle: %0d, required %0d", done_c, last_acc_c + 1); end
        n_checks++;
        if (bus.ReadReg !== '0 || bus.Busy !== 1'b0) begin
            n_fail++; $display("FAIL full_end_state: ReadReg=%0h Busy=%0b, required 0 and 0", bus.ReadReg, bus.Busy);
        end
    endtask

    task automatic test_backpressure();
        fill_rf(0);
        run_burst(5, 3, -1, -1, 0);
        n_checks++;
        if (held_d_q.size() !== 3) begin n_fail++; $display("FAIL bp_stall_len: %0d, required 3", held_d_q.size()); end
        for (int i = 0; i < held_d_q.size(); i++) begin
            n_checks++;
            if (held_d_q[i] !== rf[5] || held_r_q[i] !== ADDRESS'((5 + 1) % DATANUM)) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: DataOut=%0h ReadReg=%0h, required %0h and %0h",
                         i, held_d_q[i], held_r_q[i], rf[5], (5 + 1) % DATANUM);
            end
        end
        n_checks++;
        if (got_q.size() !== DATANUM) begin n_fail++; $display("FAIL bp_beat_count: %0d, required %0d", got_q.size(), DATANUM); end
        for (int k = 0; k < got_q.size() && k < DATANUM; k++) begin
            n_checks++;
            if (got_q[k] !== rf[k]) begin n_fail++; $display("FAIL bp_beat_%0d: %0h, required %0h", k, got_q[k], rf[k]); end
        end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count: %0d, required 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        fill_rf(0);
        run_burst(-1, 0, 7, -1, 0);
        n_checks++;
        if (got_q.size() !== DATANUM) begin n_fail++; $display("FAIL restart_beat_count: %0d, required %0d", got_q.size(), DATANUM); end
        for (int k = 0; k < got_q.size() && k < DATANUM; k++) begin
            n_checks++;
            if (got_q[k] !== rf[k]) begin n_fail++; $display("FAIL restart_beat_%0d: %0h, required %0h", k, got_q[k], rf[k]); end
        end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL restart_done_count: %0d, required 1", done_cnt); end
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.OutValid !== 1'b0) begin
            n_fail++; $display("FAIL restart_idle_after: Busy=%0b OutValid=%0b, required 0 and 0", bus.Busy, bus.OutValid);
        end
    endtask

    task automatic test_reset_mid_burst();
        fill_rf(0);
        run_burst(-1, 0, -1, 9, 0);
        n_checks++;
        if (aborted !== 1) begin n_fail++; $display("FAIL midrst_reached: aborted=%0b, required 1", aborted); end
        n_checks++;
        if ({rst_rr, rst_do, rst_ov, rst_busy, rst_done} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: ReadReg=%0h DataOut=%0h OutValid=%0b Busy=%0b Done=%0b, required all 0",
                     rst_rr, rst_do, rst_ov, rst_busy, rst_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(-1, 0, -1, -1, 0);
        n_checks++;
        if (got_q.size() !== DATANUM) begin n_fail++; $display("FAIL midrst_beat_count: %0d, required %0d", got_q.size(), DATANUM); end
        for (int k = 0; k < got_q.size() && k < DATANUM; k++) begin
            n_checks++;
            if (got_q[k] !== rf[k]) begin n_fail++; $display("FAIL midrst_beat_%0d: %0h, required %0h", k, got_q[k], rf[k]); end
        end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL midrst_done_count: %0d, required 1", done_cnt); end
    endtask

    task automatic test_random_stream();
        for (int it = 0; it < 4; it++) begin
            fill_rf(1);
            run_burst(-1, 0, (it == 2) ? 3 : -1, -1, 1);
            n_checks++;
            if (timeout !== 0) begin n_fail++; $display("FAIL rnd%0d_timeout: burst never completed, required Done", it); end
            n_checks++;
            if (got_q.size() !== DATANUM) begin n_fail++; $display("FAIL rnd%0d_beat_count: %0d, required %0d", it, got_q.size(), DATANUM); end
            for (int k = 0; k < got_q.size() && k < DATANUM; k++) begin
                n_checks++;
                if (got_q[k] !== rf[k]) begin n_fail++; $display("FAIL rnd%0d_beat_%0d: %0h, required %0h", it, k, got_q[k], rf[k]); end
            end
            n_checks++;
            if (done_cnt !== 1 || done_c !== last_acc_c + 1) begin
                n_fail++; $display("FAIL rnd%0d_done: count %0d at cycle %0d, required 1 at %0d", it, done_cnt, done_c, last_acc_c + 1);
            end
        end
    endtask

`ifdef READ_LAST_EN
    task automatic test_out_last();
        fill_rf(0);
        run_burst(DATANUM - 1, 3, -1, -1, 0);
        n_checks++;
        if (held_l_q.size() !== 3) begin n_fail++; $display("FAIL last_stall_len: %0d, required 3", held_l_q.size()); end
        for (int i = 0; i < held_l_q.size(); i++) begin
            n_checks++;
            if (held_l_q[i] !== 1'b1 || held_d_q[i] !== rf[DATANUM-1]) begin
                n_fail++; $display("FAIL last_hold_%0d: OutLast=%0b DataOut=%0h, required 1 and %0h", i, held_l_q[i], held_d_q[i], rf[DATANUM-1]);
            end
        end
        for (int k = 0; k < last_q.size(); k++) begin
            n_checks++;
            if (last_q[k] !== (k == DATANUM - 1)) begin
                n_fail++; $display("FAIL last_beat_%0d: OutLast=%0b, required %0b", k, last_q[k], (k == DATANUM - 1));
            end
        end
        n_checks++;
        if (bus.OutLast !== 1'b0) begin n_fail++; $display("FAIL last_after_burst: %0b, required 0", bus.OutLast); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_burst();
        test_random_stream();
`ifdef READ_LAST_EN
        test_out_last();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
